// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-bit indices, FSM states
// and the latched memory-request payload.
package mem_stage_pkg;

   localparam int unsigned M_WRITE     = 0;
   localparam int unsigned M_READ      = 1;
   localparam int unsigned M_BRANCH    = 2;

   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned REG_W       = 5;
   localparam int unsigned M_W         = 4;
   localparam int unsigned WB_W        = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Request captured on entry to BUSY; upstream inputs are ignored afterwards.
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] wdata;
      logic [REG_W-1:0]  rd;
      logic [WB_W-1:0]   wb;
      logic              is_store;
   } mem_req_t;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage bundled as one interface.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic                 zero;
   logic [DATA_W-1:0]    result;
   logic [DATA_W-1:0]    write_data;
   logic [REG_W-1:0]     RegDest;
   logic [M_W-1:0]       control_signals_M;
   logic [WB_W-1:0]      control_signals_WB;

   logic                 stall;
   logic                 pc_src;
   logic [DATA_W-1:0]    read_data_out;
   logic [DATA_W-1:0]    result_out;
   logic [REG_W-1:0]     RegDestOut;
   logic [WB_W-1:0]      control_signals_WB_out;
   logic                 align_err;

   modport master (
      output zero, result, write_data, RegDest, control_signals_M, control_signals_WB,
      input  stall, pc_src, read_data_out, result_out, RegDestOut,
             control_signals_WB_out, align_err
   );

   modport slave (
      input  zero, result, write_data, RegDest, control_signals_M, control_signals_WB,
      output stall, pc_src, read_data_out, result_out, RegDestOut,
             control_signals_WB_out, align_err
   );

endinterface

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read, no reset.
module data_mem
   import mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data-memory access FSM with upstream stall,
// MEM/WB pipeline register, sticky alignment flag and branch-taken generation.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned LAT    = 2
) (
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.slave bus
);

   localparam int unsigned CNT_W = 4;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   mem_req_t            r_req;

   logic [DATA_W-1:0]   r_rdata, r_res;
   logic [REG_W-1:0]    r_rd;
   logic [WB_W-1:0]     r_wb;
   logic                r_align_err;

   logic                w_is_store, w_is_load, w_req;
   logic                w_stall, w_latch, w_we, w_align_set;
   logic [DATA_W-1:0]   w_mem_rdata, w_rdata_nxt, w_res_nxt;
   logic [REG_W-1:0]    w_rd_nxt;
   logic [WB_W-1:0]     w_wb_nxt;
   logic [ADDR_W-1:0]   w_idx;
   logic                w_unused;

   assign w_is_store = bus.control_signals_M[M_WRITE];
   assign w_is_load  = bus.control_signals_M[M_READ];
   assign w_req      = w_is_store | w_is_load;
   assign w_idx      = r_req.result[ADDR_W+1:2];
   assign w_unused   = bus.control_signals_M[3];

   data_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_idx),
      .i_wdata (r_req.wdata),
      .i_raddr (w_idx),
      .o_rdata (w_mem_rdata)
   );

   // Next-state and MEM/WB next values; bubbles are the all-zero default.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_latch     = 1'b0;
      w_we        = 1'b0;
      w_align_set = 1'b0;
      w_rdata_nxt = '0;
      w_res_nxt   = '0;
      w_rd_nxt    = '0;
      w_wb_nxt    = '0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_stall     = 1'b1;
               w_latch     = 1'b1;
               w_align_set = |bus.result[1:0];
               w_cnt_nxt   = CNT_W'(LAT - 1);
               w_state_nxt = BUSY;
            end else begin
               w_res_nxt = bus.result;
               w_rd_nxt  = bus.RegDest;
               w_wb_nxt  = bus.control_signals_WB;
            end
         end
         BUSY: begin
            if (r_cnt != '0) begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               w_we        = r_req.is_store;
               w_rdata_nxt = r_req.is_store ? '0 : w_mem_rdata;
               w_res_nxt   = r_req.result;
               w_rd_nxt    = r_req.rd;
               w_wb_nxt    = r_req.wb;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_req       <= '0;
         r_rdata     <= '0;
         r_res       <= '0;
         r_rd        <= '0;
         r_wb        <= '0;
         r_align_err <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_req <= '{result:   bus.result,
                       wdata:    bus.write_data,
                       rd:       bus.RegDest,
                       wb:       bus.control_signals_WB,
                       is_store: w_is_store};
         end
         r_rdata <= w_rdata_nxt;
         r_res   <= w_res_nxt;
         r_rd    <= w_rd_nxt;
         r_wb    <= w_wb_nxt;
         if (w_align_set) begin
            r_align_err <= 1'b1;
         end
      end
   end

   // Stall is forced low during reset so an abandoned access releases the pipe at once.
   assign bus.stall                  = w_stall & ~rst;
   assign bus.pc_src                 = bus.control_signals_M[M_BRANCH] & bus.zero;
   assign bus.read_data_out          = r_rdata;
   assign bus.result_out             = r_res;
   assign bus.RegDestOut             = r_rd;
   assign bus.control_signals_WB_out = r_wb;
   assign bus.align_err              = r_align_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with DEPTH=256, ADDR_W=8, LAT=2.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_stage_if bus ();

   mem_stage #(
      .DEPTH  (256),
      .ADDR_W (8),
      .LAT    (2)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] m, input logic [1:0] wb, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic z);
      bus.control_signals_M  = m;
      bus.control_signals_WB = wb;
      bus.result             = addr;
      bus.write_data         = wdata;
      bus.RegDest            = rd;
      bus.zero               = z;
   endtask

   task automatic nop();
      drive(4'b0000, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0);
   endtask

   // One LAT=2 memory op: stall on request and first BUSY cycle, release, then MEM/WB update.
   task automatic do_mem(input string tag, input logic [3:0] m, input logic [1:0] wb,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                         input logic z, input logic exp_pc, input logic [31:0] exp_rdata);
      drive(m, wb, addr, wdata, rd, z);
      #1;
      chk({tag, ".stall0"}, 32'(bus.stall), 32'd1);
      chk({tag, ".pc0"}, 32'(bus.pc_src), 32'(exp_pc));
      tick();
      chk({tag, ".stall1"}, 32'(bus.stall), 32'd1);
      chk({tag, ".bubble_wb1"}, 32'(bus.control_signals_WB_out), 32'd0);
      chk({tag, ".bubble_rd1"}, 32'(bus.RegDestOut), 32'd0);
      chk({tag, ".pc1"}, 32'(bus.pc_src), 32'(exp_pc));
      tick();
      chk({tag, ".stall2"}, 32'(bus.stall), 32'd0);
      chk({tag, ".bubble_res2"}, bus.result_out, 32'd0);
      tick();
      chk({tag, ".rdata"}, bus.read_data_out, exp_rdata);
      chk({tag, ".res"}, bus.result_out, addr);
      chk({tag, ".rd"}, 32'(bus.RegDestOut), 32'(rd));
      chk({tag, ".wb"}, 32'(bus.control_signals_WB_out), 32'(wb));
      nop();
   endtask

   initial begin
      nop();
      tick();
      tick();
      chk("reset.stall", 32'(bus.stall), 32'd0);
      chk("reset.res", bus.result_out, 32'd0);
      chk("reset.rdata", bus.read_data_out, 32'd0);
      chk("reset.wb", 32'(bus.control_signals_WB_out), 32'd0);
      chk("reset.align", 32'(bus.align_err), 32'd0);
      rst = 1'b0;
      tick();

      // Preload word 0x20 with zero, then abandon a store to it with a reset.
      do_mem("preload", 4'b0001, 2'b00, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0);
      drive(4'b0001, 2'b00, 32'h20, 32'h1234_5678, 5'd0, 1'b0);
      tick();
      chk("rstmid.busy_stall", 32'(bus.stall), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstmid.stall", 32'(bus.stall), 32'd0);
      chk("rstmid.res", bus.result_out, 32'd0);
      chk("rstmid.rdata", bus.read_data_out, 32'd0);
      chk("rstmid.rd", 32'(bus.RegDestOut), 32'd0);
      nop();
      tick();
      rst = 1'b0;
      tick();
      chk("rstmid.idle_stall", 32'(bus.stall), 32'd0);
      do_mem("rstmid.load", 4'b0010, 2'b11, 32'h20, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0);

      // ALU pass-through.
      drive(4'b0000, 2'b01, 32'h0000_00AA, 32'h0, 5'd5, 1'b0);
      #1;
      chk("alu.stall", 32'(bus.stall), 32'd0);
      tick();
      chk("alu.res", bus.result_out, 32'h0000_00AA);
      chk("alu.rd", 32'(bus.RegDestOut), 32'd5);
      chk("alu.wb", 32'(bus.control_signals_WB_out), 32'd1);
      chk("alu.rdata", bus.read_data_out, 32'd0);
      nop();

      // Store then load the same word.
      do_mem("st40", 4'b0001, 2'b00, 32'h40, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'h0);
      do_mem("ld40", 4'b0010, 2'b11, 32'h40, 32'h0, 5'd7, 1'b0, 1'b0, 32'hDEAD_BEEF);

      // Address wrap modulo 256 words.
      do_mem("st400", 4'b0001, 2'b00, 32'h400, 32'hCAFE_0001, 5'd0, 1'b0, 1'b0, 32'h0);
      do_mem("ld0", 4'b0010, 2'b11, 32'h0, 32'h0, 5'd9, 1'b0, 1'b0, 32'hCAFE_0001);
      chk("wrap.align", 32'(bus.align_err), 32'd0);

      // Misaligned load returns the enclosing word and sets the sticky flag.
      do_mem("ld42", 4'b0010, 2'b11, 32'h42, 32'h0, 5'd10, 1'b0, 1'b0, 32'hDEAD_BEEF);
      chk("mis.align", 32'(bus.align_err), 32'd1);
      tick();
      tick();
      chk("mis.sticky", 32'(bus.align_err), 32'd1);

      // MemRead and MemWrite together behave as a store.
      do_mem("both80", 4'b0011, 2'b00, 32'h80, 32'h5A5A_5A5A, 5'd4, 1'b0, 1'b0, 32'h0);
      do_mem("ld80", 4'b0010, 2'b11, 32'h80, 32'h0, 5'd11, 1'b0, 1'b0, 32'h5A5A_5A5A);

      // Branch-taken generation.
      drive(4'b0100, 2'b00, 32'h0, 32'h0, 5'd0, 1'b1);
      #1;
      chk("br.taken", 32'(bus.pc_src), 32'd1);
      chk("br.stall", 32'(bus.stall), 32'd0);
      bus.zero = 1'b0;
      #1;
      chk("br.not_taken", 32'(bus.pc_src), 32'd0);
      tick();
      do_mem("br_ld", 4'b0110, 2'b11, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, 32'hCAFE_0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
